data_memory_responder: RTL and testbench

- Memory-side responder for the core's load/store port. It is the slave end of the data-memory request/response interface used by the pipelined RISC-V core.
- Accepts one request at a time on a valid/ready handshake, inserts a configurable number of wait states, then performs the byte, halfword or word access with RV32I alignment and sign/zero-extension rules.
- Returns the result on a response valid/ready handshake; the core stalls its MEM stage on it.

---
 rtl/data_memory_responder_pkg.sv | 18 +
 rtl/data_memory_responder_if.sv | 26 ++
 rtl/data_memory_responder_align.sv | 49 ++++
 rtl/data_memory_responder.sv | 116 +++++++++++
 tb/tb_data_memory_responder.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared encodings for the core's data-memory request/response port.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bus between the core (master) and the memory responder (slave).
interface data_memory_responder_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

endinterface

// File: rtl/data_memory_responder_align.sv
// Byte-lane steering for RV32I loads/stores: enables, replicated store data, alignment, extension.
// Latency: purely combinational.
// Backpressure: none.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = raw_word[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    load_data  = raw_word;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        byte_en    = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        load_data  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      end
      SIZE_WORD: begin
        byte_en    = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the core's load/store port: one request at a time, RV32I access rules.
// Latency: IDLE accept, WAIT_STATES wait cycles, one ACCESS cycle, then response held in RESP.
// Backpressure: response held stable until rsp_ready_i; no new request accepted outside IDLE.
module data_memory_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DATA_MEMORY_DEPTH = 128,
  parameter logic [31:0] BASE_ADDR         = DEFAULT_BASE_ADDR,
  parameter int          WAIT_STATES       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int          IDX_W     = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DATA_MEMORY_DEPTH);

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic        write_q, unsigned_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic [31:0] mem [DATA_MEMORY_DEPTH];

  logic [31:0]      off;
  logic [IDX_W-1:0] word_idx;
  logic             out_of_range, misaligned, access_err;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep, load_data, raw_word;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign off          = addr_q - BASE_ADDR;
  assign word_idx     = off[IDX_W+1:2];
  assign out_of_range = (off >= MEM_BYTES);
  assign raw_word     = mem[word_idx];
  assign access_err   = out_of_range | misaligned | (size_q == SIZE_ILLEGAL);

  load_store_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .raw_word    (raw_word),
    .byte_en     (byte_en),
    .wdata_rep   (wdata_rep),
    .misaligned  (misaligned),
    .load_data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid_i) state_next = (WAIT_STATES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt <= 4'd1) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = (state == IDLE);
    bus.rsp_valid_o = (state == RESP);
    bus.rsp_rdata_o = rdata_q;
    bus.rsp_error_o = error_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      rdata_q    <= 32'd0;
      error_q    <= 1'b0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= SIZE_BYTE;
    end else begin
      case (state)
        IDLE: if (bus.req_valid_i) begin
          write_q    <= bus.req_write_i;
          addr_q     <= bus.req_addr_i;
          wdata_q    <= bus.req_wdata_i;
          size_q     <= bus.req_size_i;
          unsigned_q <= bus.req_unsigned_i;
          wait_cnt   <= 4'(WAIT_STATES);
        end
        WAIT: wait_cnt <= wait_cnt - 4'd1;
        ACCESS: begin
          error_q <= access_err;
          rdata_q <= (!access_err && !write_q) ? load_data : 32'd0;
        end
        default: ;
      endcase
    end
  end

  // Reset outranks the write enable so a store caught in ACCESS is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && write_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder against a byte-array reference model.
module tb_data_memory_responder;
  import riscv_mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_responder_if bus ();
  data_memory_responder_if bus0 ();

  data_memory_responder #(.DATA_MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  data_memory_responder #(.DATA_MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [7:0]  ref_mem [4*DEPTH];
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  bit   rand_bp = 1'b0;
  logic bp_rand = 1'b1;
  logic rsp_ready_dir = 1'b1;
  assign bus.rsp_ready_i = rand_bp ? bp_rand : rsp_ready_dir;
  always @(posedge clk) begin
    #1;
    bp_rand = ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Memory viewed as little-endian bytes; extension done arithmetically.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic uns);
    exp_t e;
    int n;
    logic [31:0] off, v;
    off = addr - BASE;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    e.rdata = 32'd0;
    if (n == 0) e.err = 1'b1;
    else e.err = (off >= 32'(4*DEPTH)) || ((int'(addr[1:0]) % n) != 0);
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[off + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[off + 32'(i)]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Monitor: pops on every response handshake, checks hold-stability while stalled.
  logic        prev_pend = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;
  always @(negedge clk) begin
    if (reset) begin
      prev_pend = 1'b0;
    end else if (bus.rsp_valid_o) begin
      chk("req_ready_in_resp", 32'(bus.req_ready_o), 32'd0);
      if (prev_pend) begin
        chk("rdata_stable", bus.rsp_rdata_o, prev_rdata);
        chk("error_stable", 32'(bus.rsp_error_o), 32'(prev_err));
      end
      if (bus.rsp_ready_i) begin
        prev_pend = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata_o, mon_e.rdata);
          chk("rsp_error", 32'(bus.rsp_error_o), 32'(mon_e.err));
          last_rdata = bus.rsp_rdata_o;
          last_err   = bus.rsp_error_o;
        end
      end else begin
        prev_pend  = 1'b1;
        prev_rdata = bus.rsp_rdata_o;
        prev_err   = bus.rsp_error_o;
      end
    end else begin
      if (prev_pend) chk("rsp_valid_dropped", 32'd0, 32'd1);
      prev_pend = 1'b0;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, input bit expect_rsp, output int waited);
    bit got;
    bus.req_write_i    = wr;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_valid_i    = 1'b1;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (bus.req_ready_o) got = 1'b1;
      else waited++;
    end
    chk("req_accept", 32'(got), 32'd1);
    if (got && expect_rsp) sb_q.push_back(model(wr, addr, wd, sz, uns));
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic op(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz,
                    input logic uns, input string name, input logic [31:0] exp_rdata, input logic exp_err);
    int w;
    do_req(wr, addr, wd, sz, uns, 1'b1, w);
    wait_idle();
    chk({name, "_rdata"}, last_rdata, exp_rdata);
    chk({name, "_error"}, 32'(last_err), 32'(exp_err));
  endtask

  task automatic check_latency(input int exp_k);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 50) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
      else begin
        chk("req_ready_low_busy", 32'(bus.req_ready_o), 32'd0);
        k++;
      end
    end
    chk("rsp_latency", 32'(k), 32'(exp_k));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({name, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({name, "_rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
    chk({name, "_rsp_error"}, 32'(bus.rsp_error_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int w, k;
    bit seen;
    logic [31:0] word0, word8, a, d;
    logic [1:0] sz;

    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0;   bus.req_size_i = '0;    bus.req_unsigned_i = 1'b0;
    bus0.req_valid_i = 1'b0; bus0.req_write_i = 1'b0; bus0.req_addr_i = '0;
    bus0.req_wdata_i = '0;   bus0.req_size_i = '0;    bus0.req_unsigned_i = 1'b0;
    bus0.rsp_ready_i = 1'b1;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset0_req_ready", 32'(bus0.req_ready_o), 32'd1);
    chk("reset0_rsp_valid", 32'(bus0.rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, BASE + 32'(4*i), $urandom, SIZE_WORD, 1'b0, 1'b1, w);
    wait_idle();

    // Store/load round trip with latency check.
    do_req(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 1'b1, w);
    check_latency(2);
    wait_idle();
    chk("t1_sw_error", 32'(last_err), 32'd0);
    do_req(1'b0, 32'h1001_0004, 32'd0, SIZE_WORD, 1'b0, 1'b1, w);
    check_latency(2);
    wait_idle();
    chk("t1_lw_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t1_lw_error", 32'(last_err), 32'd0);

    op(1'b0, 32'h1001_0007, 32'd0, SIZE_BYTE, 1'b0, "t2_lb",  32'hFFFF_FFDE, 1'b0);
    op(1'b0, 32'h1001_0007, 32'd0, SIZE_BYTE, 1'b1, "t2_lbu", 32'h0000_00DE, 1'b0);
    op(1'b0, 32'h1001_0006, 32'd0, SIZE_HALF, 1'b0, "t2_lh",  32'hFFFF_DEAD, 1'b0);
    op(1'b0, 32'h1001_0006, 32'd0, SIZE_HALF, 1'b1, "t2_lhu", 32'h0000_DEAD, 1'b0);

    op(1'b1, 32'h1001_0005, 32'h0000_0055, SIZE_BYTE, 1'b0, "t3_sb", 32'd0, 1'b0);
    op(1'b0, 32'h1001_0004, 32'd0,         SIZE_WORD, 1'b0, "t3_lw1", 32'hDEAD_55EF, 1'b0);
    op(1'b1, 32'h1001_0004, 32'h0000_1234, SIZE_HALF, 1'b0, "t3_sh", 32'd0, 1'b0);
    op(1'b0, 32'h1001_0004, 32'd0,         SIZE_WORD, 1'b0, "t3_lw2", 32'hDEAD_1234, 1'b0);

    word0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
    op(1'b1, 32'h1001_0002, 32'h5555_5555, SIZE_WORD, 1'b0, "t4_sw_mis", 32'd0, 1'b1);
    op(1'b0, 32'h1001_0000, 32'd0, SIZE_WORD, 1'b0, "t4_lw_keep", word0, 1'b0);
    op(1'b0, 32'h1001_0001, 32'd0, SIZE_HALF, 1'b0, "t4_lh_mis", 32'd0, 1'b1);
    op(1'b0, 32'h1001_0200, 32'd0, SIZE_WORD, 1'b0, "t4_lw_top", 32'd0, 1'b1);
    op(1'b0, 32'h1000_FFFC, 32'd0, SIZE_WORD, 1'b0, "t4_lw_below", 32'd0, 1'b1);
    op(1'b0, 32'h1001_0004, 32'd0, SIZE_ILLEGAL, 1'b0, "t4_size3", 32'd0, 1'b1);

    // Response stall with a new request already waiting.
    rsp_ready_dir = 1'b0;
    do_req(1'b0, 32'h1001_0004, 32'd0, SIZE_WORD, 1'b0, 1'b1, w);
    bus.req_write_i = 1'b0; bus.req_addr_i = 32'h1001_0004; bus.req_size_i = SIZE_BYTE;
    bus.req_unsigned_i = 1'b1; bus.req_valid_i = 1'b1;
    k = 0;
    while (!bus.rsp_valid_o && k < 50) begin @(negedge clk); k++; end
    chk("t5_rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_still_valid", 32'(bus.rsp_valid_o), 32'd1);
    @(posedge clk); #1;
    rsp_ready_dir = 1'b1;
    do_req(1'b0, 32'h1001_0004, 32'd0, SIZE_BYTE, 1'b1, 1'b1, w);
    chk("t5_accept_delay", 32'(w), 32'd1);
    chk("t5_held_rdata", last_rdata, 32'hDEAD_1234);
    wait_idle();
    chk("t5_lbu_rdata", last_rdata, 32'h0000_0034);

    // Reset while a store sits in WAIT, then in ACCESS.
    word8 = {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]};
    do_req(1'b1, 32'h1001_0008, 32'hAAAA_AAAA, SIZE_WORD, 1'b0, 1'b0, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_wait");
    @(posedge clk); #1;
    do_req(1'b1, 32'h1001_0008, 32'hAAAA_AAAA, SIZE_WORD, 1'b0, 1'b0, w);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_access");
    @(posedge clk); #1;
    op(1'b0, 32'h1001_0008, 32'd0, SIZE_WORD, 1'b0, "t6_lw", word8, 1'b0);

    // Randomized traffic with random response backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 64));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 4*DEPTH - 1));
      endcase
      sz = ($urandom_range(0, 15) == 0) ? SIZE_ILLEGAL : 2'($urandom_range(0, 2));
      d = $urandom;
      do_req(1'($urandom_range(0, 1)), a, d, sz, 1'($urandom_range(0, 1)), 1'b1, w);
    end
    wait_idle();
    rand_bp = 1'b0;

    // Zero wait states: two-edge latency.
    bus0.req_write_i = 1'b1; bus0.req_addr_i = BASE + 32'd16; bus0.req_wdata_i = 32'h0BAD_F00D;
    bus0.req_size_i = SIZE_WORD; bus0.req_unsigned_i = 1'b0; bus0.req_valid_i = 1'b1;
    @(negedge clk);
    chk("d0_sw_ready", 32'(bus0.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus0.req_valid_i = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 50) begin @(negedge clk); if (bus0.rsp_valid_o) seen = 1'b1; else k++; end
    chk("d0_sw_latency", 32'(k), 32'd1);
    chk("d0_sw_error", 32'(bus0.rsp_error_o), 32'd0);
    @(posedge clk); #1;
    bus0.req_write_i = 1'b0; bus0.req_valid_i = 1'b1;
    @(negedge clk);
    chk("d0_lw_ready", 32'(bus0.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus0.req_valid_i = 1'b0;
    k = 0; seen = 1'b0;
    while (!seen && k < 50) begin @(negedge clk); if (bus0.rsp_valid_o) seen = 1'b1; else k++; end
    chk("d0_lw_latency", 32'(k), 32'd1);
    chk("d0_lw_rdata", bus0.rsp_rdata_o, 32'h0BAD_F00D);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
